expr_vector_driver: RTL and testbench

Stimulus and response engine for the combinational expression blocks in the regression set. It sits on the other side of an expression module's ports. It generates pseudo-random operand vectors for the six `a*` and six `b*` inputs, then waits for each 90-bit packed `y` result. Each result is folded into a multiple-input signature register (MISR), so a whole run reduces to one signature that can be compared against a golden value.

---
 rtl/expr_vector_driver_pkg.sv | 49 ++++
 rtl/expr_vector_driver_misr.sv | 32 +++
 rtl/expr_vector_driver.sv | 135 +++++++++++++
 tb/tb_expr_vector_driver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_vector_driver_pkg.sv
// expr_vec_pkg: shared constants and types for the expression-vector driver.
//   - operand widths and field offsets within the 60-bit operand LFSR
//   - LFSR / MISR widths and feedback tap positions
//   - FSM state encoding
//   - LFSR step helper
package expr_vec_pkg;

    localparam int LFSR_W = 60;
    localparam int MISR_W = 90;

    // Operand widths: index 0 -> 4 bits, 1 -> 5 bits, 2 -> 6 bits (repeats for 3..5)
    localparam int OP_W0 = 4;
    localparam int OP_W1 = 5;
    localparam int OP_W2 = 6;

    // LSB position of each operand field inside the LFSR, MSB-first packing
    localparam int A0_LSB = 56;
    localparam int A1_LSB = 51;
    localparam int A2_LSB = 45;
    localparam int A3_LSB = 41;
    localparam int A4_LSB = 36;
    localparam int A5_LSB = 30;
    localparam int B0_LSB = 26;
    localparam int B1_LSB = 21;
    localparam int B2_LSB = 15;
    localparam int B3_LSB = 11;
    localparam int B4_LSB = 6;
    localparam int B5_LSB = 0;

    // Feedback taps
    localparam int LFSR_TAP_HI = 59;
    localparam int LFSR_TAP_LO = 58;
    localparam int MISR_TAP_0  = 89;
    localparam int MISR_TAP_1  = 88;
    localparam int MISR_TAP_2  = 4;
    localparam int MISR_TAP_3  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/expr_vector_driver_misr.sv
// expr_misr: 90-bit multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset (clears the signature)
//   clear      : synchronous clear, takes priority over en
//   en         : absorb din this cycle
//   din        : 90-bit word folded into the signature
//   sig        : current signature
module expr_misr
    import expr_vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic feedback;

    assign feedback = sig[MISR_TAP_0] ^ sig[MISR_TAP_1] ^ sig[MISR_TAP_2] ^ sig[MISR_TAP_3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[MISR_W-2:0], feedback} ^ din;
        end
    end

endmodule

// File: rtl/expr_vector_driver.sv
// expr_vector_driver: drives pseudo-random operand vectors into a combinational
// expression block and compresses each 90-bit result into a MISR signature.
//   start               : begin a run (ignored while busy)
//   op_valid / op_ready : operand handshake; operands a0..a5, b0..b5
//   res_valid / y_i     : result for the last accepted vector
//   busy, done          : run status; done holds until the next start
//   signature           : MISR contents
//   vec_count           : results absorbed in the current run
module expr_vector_driver
    import expr_vec_pkg::*;
#(
    parameter int                NUM_VECTORS = 256,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 60'h0000_0000_0000_001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [OP_W0-1:0]        a0,
    output logic [OP_W1-1:0]        a1,
    output logic [OP_W2-1:0]        a2,
    output logic signed [OP_W0-1:0] a3,
    output logic signed [OP_W1-1:0] a4,
    output logic signed [OP_W2-1:0] a5,
    output logic [OP_W0-1:0]        b0,
    output logic [OP_W1-1:0]        b1,
    output logic [OP_W2-1:0]        b2,
    output logic signed [OP_W0-1:0] b3,
    output logic signed [OP_W1-1:0] b4,
    output logic signed [OP_W2-1:0] b5,
    input  logic                    res_valid,
    input  logic [MISR_W-1:0]       y_i,
    output logic                    busy,
    output logic                    done,
    output logic [MISR_W-1:0]       signature,
    output logic [15:0]             vec_count
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [15:0]       LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t            state_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    // Operand snapshot: the LFSR advances during WAIT, but operands must
    // stay stable until the next DRIVE, so they are latched separately.
    logic [LFSR_W-1:0] ops_reg;
    logic [15:0]       vec_count_reg;
    logic              op_valid_reg;
    logic              busy_reg;
    logic              done_reg;

    logic start_accept;
    logic absorb;

    assign start_accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign absorb       = (state_reg == WAIT) && res_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lfsr_reg      <= LFSR_W'(1);
            ops_reg       <= '0;
            vec_count_reg <= '0;
            op_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr_reg      <= SEED_EFF;
                        ops_reg       <= SEED_EFF;
                        vec_count_reg <= '0;
                        op_valid_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        state_reg     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (op_ready) begin
                        op_valid_reg <= 1'b0;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        lfsr_reg      <= lfsr_step(lfsr_reg);
                        vec_count_reg <= vec_count_reg + 16'd1;
                        if (vec_count_reg == LAST_IDX) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            ops_reg      <= lfsr_step(lfsr_reg);
                            op_valid_reg <= 1'b1;
                            state_reg    <= DRIVE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    expr_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_accept),
        .en    (absorb),
        .din   (y_i),
        .sig   (signature)
    );

    assign op_valid  = op_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign vec_count = vec_count_reg;

    assign a0 = ops_reg[A0_LSB +: OP_W0];
    assign a1 = ops_reg[A1_LSB +: OP_W1];
    assign a2 = ops_reg[A2_LSB +: OP_W2];
    assign a3 = $signed(ops_reg[A3_LSB +: OP_W0]);
    assign a4 = $signed(ops_reg[A4_LSB +: OP_W1]);
    assign a5 = $signed(ops_reg[A5_LSB +: OP_W2]);
    assign b0 = ops_reg[B0_LSB +: OP_W0];
    assign b1 = ops_reg[B1_LSB +: OP_W1];
    assign b2 = ops_reg[B2_LSB +: OP_W2];
    assign b3 = $signed(ops_reg[B3_LSB +: OP_W0]);
    assign b4 = $signed(ops_reg[B4_LSB +: OP_W1]);
    assign b5 = $signed(ops_reg[B5_LSB +: OP_W2]);

endmodule

// File: tb/tb_expr_vector_driver.sv
module tb_expr_vector_driver;

    localparam int          M_NV   = 8;
    localparam logic [59:0] M_SEED = 60'h9AB_CDEF_0123_4567;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // ---------------- main instance: randomized runs ----------------
    logic        m_start, m_op_ready, m_res_valid;
    logic [89:0] m_y;
    logic        m_op_valid, m_busy, m_done;
    logic [3:0]  m_a0, m_a3, m_b0, m_b3;
    logic [4:0]  m_a1, m_a4, m_b1, m_b4;
    logic [5:0]  m_a2, m_a5, m_b2, m_b5;
    logic [89:0] m_sig;
    logic [15:0] m_cnt;
    logic [59:0] m_ops;
    assign m_ops = {m_a0, m_a1, m_a2, m_a3, m_a4, m_a5, m_b0, m_b1, m_b2, m_b3, m_b4, m_b5};

    expr_vector_driver #(.NUM_VECTORS(M_NV), .LFSR_SEED(M_SEED)) dut_main (
        .clk(clk), .rst_n(rst_n), .start(m_start), .op_valid(m_op_valid), .op_ready(m_op_ready),
        .a0(m_a0), .a1(m_a1), .a2(m_a2), .a3(m_a3), .a4(m_a4), .a5(m_a5),
        .b0(m_b0), .b1(m_b1), .b2(m_b2), .b3(m_b3), .b4(m_b4), .b5(m_b5),
        .res_valid(m_res_valid), .y_i(m_y), .busy(m_busy), .done(m_done),
        .signature(m_sig), .vec_count(m_cnt)
    );

    // ------------- small instances: N=1 seed 1, N=2 seed 0 -------------
    logic        s_start;
    logic        s_one = 1'b1;
    logic [89:0] s_y   = 90'h1;

    logic        o_op_valid, o_busy, o_done;
    logic [3:0]  o_a0, o_a3, o_b0, o_b3;
    logic [4:0]  o_a1, o_a4, o_b1, o_b4;
    logic [5:0]  o_a2, o_a5, o_b2, o_b5;
    logic [89:0] o_sig;
    logic [15:0] o_cnt;
    logic [59:0] o_ops;
    assign o_ops = {o_a0, o_a1, o_a2, o_a3, o_a4, o_a5, o_b0, o_b1, o_b2, o_b3, o_b4, o_b5};

    expr_vector_driver #(.NUM_VECTORS(1), .LFSR_SEED(60'h1)) dut_one (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op_valid(o_op_valid), .op_ready(s_one),
        .a0(o_a0), .a1(o_a1), .a2(o_a2), .a3(o_a3), .a4(o_a4), .a5(o_a5),
        .b0(o_b0), .b1(o_b1), .b2(o_b2), .b3(o_b3), .b4(o_b4), .b5(o_b5),
        .res_valid(s_one), .y_i(s_y), .busy(o_busy), .done(o_done),
        .signature(o_sig), .vec_count(o_cnt)
    );

    logic        t_op_valid, t_busy, t_done;
    logic [3:0]  t_a0, t_a3, t_b0, t_b3;
    logic [4:0]  t_a1, t_a4, t_b1, t_b4;
    logic [5:0]  t_a2, t_a5, t_b2, t_b5;
    logic [89:0] t_sig;
    logic [15:0] t_cnt;
    logic [59:0] t_ops;
    assign t_ops = {t_a0, t_a1, t_a2, t_a3, t_a4, t_a5, t_b0, t_b1, t_b2, t_b3, t_b4, t_b5};

    expr_vector_driver #(.NUM_VECTORS(2), .LFSR_SEED(60'h0)) dut_two (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op_valid(t_op_valid), .op_ready(s_one),
        .a0(t_a0), .a1(t_a1), .a2(t_a2), .a3(t_a3), .a4(t_a4), .a5(t_a5),
        .b0(t_b0), .b1(t_b1), .b2(t_b2), .b3(t_b3), .b4(t_b4), .b5(t_b5),
        .res_valid(s_one), .y_i(s_y), .busy(t_busy), .done(t_done),
        .signature(t_sig), .vec_count(t_cnt)
    );

    // ---------------- reference model (from the operational rules) ----------------
    function automatic logic [59:0] model_lfsr_next(input logic [59:0] s);
        return {s[58:0], s[59] ^ s[58]};
    endfunction

    function automatic logic [89:0] model_misr_next(input logic [89:0] m, input logic [89:0] y);
        return {m[88:0], m[89] ^ m[88] ^ m[4] ^ m[2]} ^ y;
    endfunction

    function automatic logic [89:0] rand_y();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[89:0];
    endfunction

    logic [89:0] ys [M_NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [89:0] zero90;
        zero90 = '0;
        rst_n = 1'b0; m_start = 0; m_op_ready = 0; m_res_valid = 0; m_y = '0; s_start = 0;
        tick(); tick();
        checks++;
        if ({m_op_valid, m_busy, m_done, m_ops, m_cnt} !== '0 || m_sig !== zero90) begin
            failures++;
            $display("FAIL reset_values: ov=%b busy=%b done=%b ops=%h cnt=%0d sig=%h, required all 0",
                     m_op_valid, m_busy, m_done, m_ops, m_cnt, m_sig);
        end
        rst_n = 1'b1;
        tick();
        // get into DRIVE, then abort with an asynchronous reset
        m_start = 1; tick(); m_start = 0;
        checks++;
        if (m_op_valid !== 1'b1 || m_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_drive_entry: ov=%b busy=%b, required 1 1", m_op_valid, m_busy);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_op_valid, m_busy, m_done, m_ops, m_cnt} !== '0 || m_sig !== zero90) begin
            failures++;
            $display("FAIL reset_async_abort: ov=%b busy=%b done=%b ops=%h cnt=%0d, required all 0",
                     m_op_valid, m_busy, m_done, m_ops, m_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (m_op_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_hold: cycle %0d ov=%b busy=%b done=%b, required 0 0 0",
                         i, m_op_valid, m_busy, m_done);
            end
        end
        $display("reset: abort mid-DRIVE checked");
    endtask

    task automatic test_single_two();
        s_start = 1; tick(); s_start = 0;
        checks++;
        if (o_op_valid !== 1'b1 || o_busy !== 1'b1 || o_ops !== 60'h1) begin
            failures++;
            $display("FAIL single_first_vector: ov=%b busy=%b ops=%h, required 1 1 %h", o_op_valid, o_busy, o_ops, 60'h1);
        end
        checks++;
        if (t_op_valid !== 1'b1 || t_ops !== 60'h1) begin
            failures++;
            $display("FAIL seed0_first_vector: ov=%b ops=%h, required 1 %h", t_op_valid, t_ops, 60'h1);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_op_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_wait: done=%b ov=%b, required 0 0", o_done, o_op_valid);
        end
        tick();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_sig !== 90'h1 || o_cnt !== 16'd1) begin
            failures++;
            $display("FAIL single_done: done=%b busy=%b sig=%h cnt=%0d, required 1 0 1 1", o_done, o_busy, o_sig, o_cnt);
        end
        checks++;
        if (t_op_valid !== 1'b1 || t_ops !== 60'h2 || t_cnt !== 16'd1) begin
            failures++;
            $display("FAIL two_second_vector: ov=%b ops=%h cnt=%0d, required 1 %h 1", t_op_valid, t_ops, t_cnt, 60'h2);
        end
        tick(); tick();
        checks++;
        if (t_done !== 1'b1 || t_sig !== 90'h3 || t_cnt !== 16'd2) begin
            failures++;
            $display("FAIL two_done: done=%b sig=%h cnt=%0d, required 1 3 2", t_done, t_sig, t_cnt);
        end
        $display("single/two: sig1=%h sig2=%h", o_sig, t_sig);
    endtask

    task automatic run_main(input bit replay, output logic [89:0] sig_out);
        logic [59:0] ml;
        logic [89:0] mm;
        logic [89:0] yv;
        int          mc;
        int          hold;
        int          gap;
        ml = M_SEED; mm = '0; mc = 0;
        m_start = 1; tick(); m_start = 0;
        checks++;
        if (m_busy !== 1'b1 || m_op_valid !== 1'b1 || m_done !== 1'b0 || m_cnt !== 16'd0) begin
            failures++;
            $display("FAIL main_start: busy=%b ov=%b done=%b cnt=%0d, required 1 1 0 0", m_busy, m_op_valid, m_done, m_cnt);
        end
        for (int v = 0; v < M_NV; v++) begin
            hold = (v == 0) ? 5 : $urandom_range(0, 3);
            checks++;
            if (m_ops !== ml) begin
                failures++;
                $display("FAIL main_operands: vec %0d ops=%h, required %h", v, m_ops, ml);
            end
            // backpressure; stray res_valid pulses here must be ignored
            for (int h = 0; h < hold; h++) begin
                m_op_ready = 0; m_res_valid = 1'($urandom_range(0, 1)); m_y = rand_y();
                tick();
                checks++;
                if (m_op_valid !== 1'b1 || m_ops !== ml || m_cnt !== 16'(mc)) begin
                    failures++;
                    $display("FAIL main_backpressure: vec %0d ov=%b ops=%h cnt=%0d, required 1 %h %0d",
                             v, m_op_valid, m_ops, m_cnt, ml, mc);
                end
            end
            m_res_valid = 0;
            m_op_ready = 1; m_start = (v == 3); // start while busy is ignored
            tick();
            m_op_ready = 0; m_start = 0;
            checks++;
            if (m_op_valid !== 1'b0 || m_busy !== 1'b1) begin
                failures++;
                $display("FAIL main_wait_entry: vec %0d ov=%b busy=%b, required 0 1", v, m_op_valid, m_busy);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                m_op_ready = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if (m_op_valid !== 1'b0 || m_cnt !== 16'(mc)) begin
                    failures++;
                    $display("FAIL main_wait_hold: vec %0d ov=%b cnt=%0d, required 0 %0d", v, m_op_valid, m_cnt, mc);
                end
            end
            m_op_ready = 0;
            yv = replay ? ys[v] : rand_y();
            ys[v] = yv;
            m_y = yv; m_res_valid = 1; m_start = (v == M_NV - 1); // start on last absorb is ignored
            tick();
            m_res_valid = 0; m_start = 0;
            mm = model_misr_next(mm, yv);
            ml = model_lfsr_next(ml);
            mc++;
            checks++;
            if (m_cnt !== 16'(mc)) begin
                failures++;
                $display("FAIL main_count: vec %0d cnt=%0d, required %0d", v, m_cnt, mc);
            end
            $display("vec %0d: hold=%0d gap=%0d y=%h cnt=%0d", v, hold, gap, yv, m_cnt);
        end
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_op_valid !== 1'b0 || m_sig !== mm) begin
            failures++;
            $display("FAIL main_done: done=%b busy=%b ov=%b sig=%h, required 1 0 0 %h", m_done, m_busy, m_op_valid, m_sig, mm);
        end
        // signature frozen in DONE
        for (int i = 0; i < 2; i++) begin
            m_res_valid = 1; m_y = rand_y();
            tick();
        end
        m_res_valid = 0;
        checks++;
        if (m_sig !== mm || m_done !== 1'b1 || m_op_valid !== 1'b0 || m_cnt !== 16'(M_NV)) begin
            failures++;
            $display("FAIL main_frozen: sig=%h done=%b ov=%b cnt=%0d, required %h 1 0 %0d", m_sig, m_done, m_op_valid, m_cnt, mm, M_NV);
        end
        sig_out = m_sig;
    endtask

    task automatic test_main();
        logic [89:0] s1, s2;
        run_main(1'b0, s1);
        run_main(1'b1, s2);
        checks++;
        if (s2 !== s1) begin
            failures++;
            $display("FAIL restart_signature: second=%h, required %h", s2, s1);
        end
        $display("main: run signature %h", s1);
    endtask

    initial begin
        test_reset();
        test_single_two();
        test_main();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
